// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with valid/ready handshake and flush.
// Define PIPE_SKID_EN to add a skid entry and make in_ready a registered output.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int LANES  = 3,
    parameter int IDX_W  = 5,
    parameter int IDXS   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CTRL_W-1:0]         in_ctrl,
    input  logic [DATA_W*LANES-1:0]   in_data,
    input  logic [IDX_W*IDXS-1:0]     in_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CTRL_W-1:0]         out_ctrl,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic [IDX_W*IDXS-1:0]     out_idx
);
    localparam int DW = DATA_W * LANES;
    localparam int XW = IDX_W * IDXS;

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;
`else
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
`endif

    state_t            state, state_nx;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DW-1:0]     main_data;
    logic [XW-1:0]     main_idx;
    logic              accept, drain, load_in, clr_main;

`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DW-1:0]     skid_data;
    logic [XW-1:0]     skid_idx;
    logic              load_skid, load_from_skid, rdy_q;

    assign in_ready = rdy_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign out_idx   = main_idx;

    always_comb begin
        state_nx = state;
        load_in  = 1'b0;
        clr_main = 1'b0;
`ifdef PIPE_SKID_EN
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
`endif
        case (state)
            EMPTY: if (accept) begin
                state_nx = FULL;
                load_in  = 1'b1;
            end
            FULL: begin
                if (drain && accept) begin
                    load_in = 1'b1;
                end else if (drain) begin
                    state_nx = EMPTY;
                    clr_main = 1'b1;
                end
`ifdef PIPE_SKID_EN
                else if (accept) begin
                    state_nx  = SKID;
                    load_skid = 1'b1;
                end
`endif
            end
`ifdef PIPE_SKID_EN
            SKID: if (drain) begin
                state_nx       = FULL;
                load_from_skid = 1'b1;
            end
`endif
            default: state_nx = EMPTY;
        endcase
        if (flush) state_nx = EMPTY;
    end

    // Invalid entries keep ctrl at zero so a bubble is a downstream no-op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            main_idx  <= '0;
`ifdef PIPE_SKID_EN
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_idx  <= '0;
            rdy_q     <= 1'b1;
`endif
        end else begin
            state <= state_nx;
`ifdef PIPE_SKID_EN
            rdy_q <= (state_nx != SKID);
`endif
            if (flush) begin
                main_ctrl <= '0;
`ifdef PIPE_SKID_EN
                skid_ctrl <= '0;
`endif
            end else begin
                if (load_in) begin
                    main_ctrl <= in_ctrl;
                    main_data <= in_data;
                    main_idx  <= in_idx;
                end
`ifdef PIPE_SKID_EN
                else if (load_from_skid) begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                    main_idx  <= skid_idx;
                end
`endif
                else if (clr_main) begin
                    main_ctrl <= '0;
                end
`ifdef PIPE_SKID_EN
                if (load_skid) begin
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                    skid_idx  <= in_idx;
                end else if (load_from_skid) begin
                    skid_ctrl <= '0;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard bench for pipe_stage_reg (LANES=4, IDXS=2); follows PIPE_SKID_EN if defined.
module tb_pipe_stage_reg;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]   in_ctrl, out_ctrl;
    logic [127:0] in_data, out_data;
    logic [9:0]   in_idx, out_idx;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .LANES(4), .IDX_W(5), .IDXS(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_idx(in_idx),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv, ordy, fl;
        logic [7:0] ctrl;
        logic       exp_rdy, exp_ov;
        logic [7:0] exp_oc;
    } vec_t;

    typedef struct {
        logic [7:0]   ctrl;
        logic [127:0] data;
        logic [9:0]   idx;
    } ent_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk_data(input logic [7:0] c);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = {c, 8'(i), 16'hBEEF};
        return d;
    endfunction

    function automatic logic [9:0] mk_idx(input logic [7:0] c);
        return {c[4:0] ^ 5'd3, c[4:0]};
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [7:0] c);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_ctrl   = c;
        in_data   = mk_data(c);
        in_idx    = mk_idx(c);
    endtask

    vec_t vecs[15];
    ent_t q[$];

    initial begin
        // {iv, ordy, fl, ctrl, exp in_ready before edge, exp out_valid, exp out_ctrl after edge}
        vecs[0]  = '{1, 1, 0, 8'd1, 1,    1, 8'd1};
        vecs[1]  = '{1, 1, 0, 8'd2, 1,    1, 8'd2};
        vecs[2]  = '{0, 1, 0, 8'd0, 1,    0, 8'd0};
        vecs[3]  = '{1, 0, 0, 8'd3, 1,    1, 8'd3};
        vecs[4]  = '{1, 0, 0, 8'd4, SKID, 1, 8'd3};
        vecs[5]  = '{1, 0, 0, 8'd4, 0,    1, 8'd3};
        vecs[6]  = '{1, 1, 0, 8'd4, !SKID, 1, 8'd4};
        vecs[7]  = '{0, 1, 0, 8'd0, 1,    0, 8'd0};
        vecs[8]  = '{1, 0, 0, 8'd5, 1,    1, 8'd5};
        vecs[9]  = '{1, 0, 0, 8'd6, SKID, 1, 8'd5};
        vecs[10] = '{1, 0, 1, 8'd9, 0,    0, 8'd0};
        vecs[11] = '{0, 1, 0, 8'd0, 1,    0, 8'd0};
        vecs[12] = '{1, 1, 0, 8'd7, 1,    1, 8'd7};
        vecs[13] = '{1, 0, 1, 8'd8, SKID, 0, 8'd0};
        vecs[14] = '{0, 1, 0, 8'd0, 1,    0, 8'd0};

        // Reset held 2 cycles while upstream offers ctrl=FF.
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'hFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_ctrl", out_ctrl, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_idx", out_idx, 0);
        chk("reset_in_ready", in_ready, 1);

        // Directed table: stall, ordering, flush in SKID/FULL.
        for (int v = 0; v < 15; v++) begin
            drive(vecs[v].iv, vecs[v].ordy, vecs[v].fl, vecs[v].ctrl);
            #2;
            chk($sformatf("vec%0d_in_ready", v), in_ready, vecs[v].exp_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", v), out_valid, vecs[v].exp_ov);
            chk($sformatf("vec%0d_out_ctrl", v), out_ctrl, vecs[v].exp_oc);
            if (vecs[v].exp_ov) begin
                chk($sformatf("vec%0d_out_data", v), out_data, mk_data(vecs[v].exp_oc));
                chk($sformatf("vec%0d_out_idx", v), out_idx, mk_idx(vecs[v].exp_oc));
            end
        end

        // Back-to-back streaming, one per cycle.
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(k));
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_valid", k), out_valid, 1);
            chk($sformatf("stream%0d_ctrl", k), out_ctrl, 8'(k));
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk("stream_end_valid", out_valid, 0);
        chk("stream_end_ctrl", out_ctrl, 0);

        // Lane packing, lane 0 at LSBs.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_ctrl   = 8'h11;
        in_data   = 128'h000000A3_000000A2_000000A1_000000A0;
        in_idx    = {5'd31, 5'd1};
        @(posedge clk);
        #1;
        chk("lanes_data", out_data, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("lanes_idx", out_idx, 10'h3E1);
        chk("lanes_ctrl", out_ctrl, 8'h11);
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        chk("lanes_drained", out_valid, 0);

        // Random traffic against a scoreboard queue.
        begin
            logic hold = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                if (!hold) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                 ($urandom_range(0, 39) == 0), 8'($urandom));
                else begin
                    out_ready = 1'($urandom_range(0, 1));
                    flush     = ($urandom_range(0, 39) == 0);
                end
                #2;
                chk("rand_in_ready", in_ready,
                    SKID ? (q.size() < 2) : (q.size() == 0 || out_ready));
                hold = in_valid && !in_ready;
                if (flush) begin
                    q.delete();
                    hold = 1'b0;
                end else begin
                    if (out_valid && out_ready) void'(q.pop_front());
                    if (in_valid && in_ready) q.push_back('{in_ctrl, in_data, in_idx});
                end
                @(posedge clk);
                #1;
                chk("rand_out_valid", out_valid, (q.size() != 0));
                if (q.size() != 0) begin
                    chk("rand_out_ctrl", out_ctrl, q[0].ctrl);
                    chk("rand_out_data", out_data, q[0].data);
                    chk("rand_out_idx", out_idx, q[0].idx);
                end else begin
                    chk("rand_bubble_ctrl", out_ctrl, 0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
